// File: rtl/dist_search_ctrl.sv
// Search controller: fetches NUM_CAND candidate matrices from the library RAM, runs each
// through the distance calculator and tracks the minimum dist2. Optional watchdog: DIST_TIMEOUT_EN.
`ifndef NUMBER_BITS
`define NUMBER_BITS 16
`endif

module dist_search_ctrl #(
  parameter int NUM_CAND  = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic signed [`NUMBER_BITS-1:0]     mtx_target [0:1][0:1][0:1],
  output logic                               lib_rd,
  output logic        [ADDR_BITS-1:0]        lib_addr,
  output logic        [2:0]                  lib_entry,
  input  logic signed [`NUMBER_BITS-1:0]     lib_data,
  output logic signed [`NUMBER_BITS-1:0]     mtx_a [0:1][0:1][0:1],
  output logic signed [`NUMBER_BITS-1:0]     mtx_b [0:1][0:1][0:1],
  output logic                               dist_ready,
  input  logic        [2*(`NUMBER_BITS+3):0] dist2,
  input  logic                               dist_finished,
  output logic                               busy,
  output logic                               done,
  output logic        [ADDR_BITS-1:0]        best_idx,
  output logic        [2*(`NUMBER_BITS+3):0] best_dist2,
  output logic                               timeout_err
);
  localparam int NB = `NUMBER_BITS;
  localparam int DW = 2*(NB+3)+1;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_CAND-1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPT, S_FIRE, S_WAIT, S_CMP, S_DONE
  } state_t;

  typedef logic signed [NB-1:0] mtx_t [0:1][0:1][0:1];

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [2:0]           ent_q, ent_d;
  logic                 pend_q, pend_d;
  logic [2:0]           pend_ent_q, pend_ent_d;
  mtx_t                 mtx_a_q, mtx_a_d;
  mtx_t                 mtx_b_q, mtx_b_d;
  logic [DW-1:0]        dist_q, dist_d;
  logic [ADDR_BITS-1:0] best_idx_q, best_idx_d;
  logic [DW-1:0]        best_q, best_d;
  logic                 take;
`ifdef DIST_TIMEOUT_EN
  logic [3:0]           wd_q, wd_d;
  logic                 skip_q, skip_d;
  logic                 tmo_q, tmo_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ent_q      <= '0;
      pend_q     <= 1'b0;
      pend_ent_q <= '0;
      mtx_a_q    <= '{default: '0};
      mtx_b_q    <= '{default: '0};
      dist_q     <= '0;
      best_idx_q <= '0;
      best_q     <= '1;
`ifdef DIST_TIMEOUT_EN
      wd_q       <= '0;
      skip_q     <= 1'b0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ent_q      <= ent_d;
      pend_q     <= pend_d;
      pend_ent_q <= pend_ent_d;
      mtx_a_q    <= mtx_a_d;
      mtx_b_q    <= mtx_b_d;
      dist_q     <= dist_d;
      best_idx_q <= best_idx_d;
      best_q     <= best_d;
`ifdef DIST_TIMEOUT_EN
      wd_q       <= wd_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ent_d      = ent_q;
    mtx_a_d    = mtx_a_q;
    mtx_b_d    = mtx_b_q;
    dist_d     = dist_q;
    best_idx_d = best_idx_q;
    best_d     = best_q;
`ifdef DIST_TIMEOUT_EN
    wd_d       = wd_q;
    skip_d     = skip_q;
    tmo_d      = tmo_q;
    take       = !skip_q && (dist_q < best_q);
`else
    take       = (dist_q < best_q);
`endif
    // Library data trails its read strobe by one cycle; entry 7 therefore lands during CAPT.
    pend_d     = (state_q == S_FETCH);
    pend_ent_d = ent_q;
    if (pend_q) mtx_a_d[pend_ent_q[2]][pend_ent_q[1]][pend_ent_q[0]] = lib_data;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          idx_d      = '0;
          ent_d      = '0;
          mtx_b_d    = mtx_target;
          best_d     = '1;
          best_idx_d = '0;
`ifdef DIST_TIMEOUT_EN
          tmo_d      = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        ent_d = ent_q + 3'd1;
        if (ent_q == 3'd7) state_d = S_CAPT;
      end
      S_CAPT: state_d = S_FIRE;
      S_FIRE: begin
        state_d = S_WAIT;
`ifdef DIST_TIMEOUT_EN
        wd_d    = '0;
        skip_d  = 1'b0;
`endif
      end
      S_WAIT: begin
        if (dist_finished) begin
          dist_d  = dist2;
          state_d = S_CMP;
`ifdef DIST_TIMEOUT_EN
        end else if (wd_q == 4'd14) begin
          // Fifteenth silent WAIT cycle: abandon this candidate.
          skip_d  = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_CMP;
        end else begin
          wd_d    = wd_q + 4'd1;
`endif
        end
      end
      S_CMP: begin
        if (take) begin
          best_d     = dist_q;
          best_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          ent_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign lib_rd     = (state_q == S_FETCH);
  assign lib_addr   = idx_q;
  assign lib_entry  = ent_q;
  assign dist_ready = (state_q == S_FIRE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign best_idx   = best_idx_q;
  assign best_dist2 = best_q;
  assign mtx_a      = mtx_a_q;
  assign mtx_b      = mtx_b_q;
`ifdef DIST_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dist_search_ctrl.sv
// Scoreboard bench for dist_search_ctrl: random library/distances, library RAM and calculator models.
`ifndef NUMBER_BITS
`define NUMBER_BITS 16
`endif

module tb_dist_search_ctrl;
  localparam int NB = `NUMBER_BITS;
  localparam int DW = 2*(NB+3)+1;
  localparam int NC = 4;
  localparam int AB = 4;
  localparam int MW = 8*NB;

  logic                 clk = 1'b0;
  logic                 reset, start;
  logic signed [NB-1:0] mtx_target [0:1][0:1][0:1];
  logic                 lib_rd;
  logic [AB-1:0]        lib_addr;
  logic [2:0]           lib_entry;
  logic signed [NB-1:0] lib_data = '0;
  logic signed [NB-1:0] mtx_a [0:1][0:1][0:1];
  logic signed [NB-1:0] mtx_b [0:1][0:1][0:1];
  logic                 dist_ready;
  logic [DW-1:0]        dist2 = '0;
  logic                 dist_finished = 1'b0;
  logic                 busy, done, timeout_err;
  logic [AB-1:0]        best_idx;
  logic [DW-1:0]        best_dist2;

  dist_search_ctrl #(.NUM_CAND(NC), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .start(start), .mtx_target(mtx_target),
    .lib_rd(lib_rd), .lib_addr(lib_addr), .lib_entry(lib_entry), .lib_data(lib_data),
    .mtx_a(mtx_a), .mtx_b(mtx_b), .dist_ready(dist_ready), .dist2(dist2),
    .dist_finished(dist_finished), .busy(busy), .done(done), .best_idx(best_idx),
    .best_dist2(best_dist2), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [MW-1:0] pack(input logic signed [NB-1:0] m [0:1][0:1][0:1]);
    logic [MW-1:0] r;
    logic [2:0]    e;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      e = 3'(k);
      r[k*NB +: NB] = m[e[2]][e[1]][e[0]];
    end
    return r;
  endfunction

  task automatic set_target(input logic [MW-1:0] f);
    logic [2:0] e;
    for (int k = 0; k < 8; k++) begin
      e = 3'(k);
      mtx_target[e[2]][e[1]][e[0]] = f[k*NB +: NB];
    end
  endtask

  function automatic logic [MW-1:0] rand_mtx();
    logic [MW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*NB +: NB] = NB'($urandom);
    return r;
  endfunction

  // Test configuration shared with the environment models
  logic [NB-1:0] mem [0:15][0:7];
  logic [DW-1:0] dtab [0:NC-1];
  logic [MW-1:0] tgt_flat;
  int            W = 1;
  int            skip_idx = -1;
  bit            spur_en = 1'b0;
  bit            quiet = 1'b1;
  int            gen = 0;
  int            start_cyc = 0;
  int            last_lat = 0;
  int            last_bidx = 0;
  logic [DW-1:0] last_best = '1;

  typedef struct { int off; int addr; logic [MW-1:0] a; logic [MW-1:0] b; } fire_t;
  typedef struct { int lat; int bidx; logic [DW-1:0] bd; bit tmo; } res_t;
  fire_t fire_q[$];
  res_t  res_q[$];

  // Synchronous library RAM: data appears in the cycle after the strobe, garbage otherwise.
  bit pv = 1'b0;
  int pa = 0, pe = 0;
  always @(negedge clk) begin
    lib_data = pv ? mem[pa][pe] : NB'($urandom);
    pv = lib_rd && !reset;
    pa = int'(lib_addr);
    pe = int'(lib_entry);
  end

  // Distance calculator: finishes W cycles after ready; may also emit spurious finishes in FETCH.
  int         cnt = 0;
  int         fire_a = 0;
  always @(negedge clk) begin
    dist_finished = 1'b0;
    dist2 = DW'({$urandom, $urandom});
    if (reset) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          dist_finished = 1'b1;
          dist2 = dtab[fire_a];
        end
      end else if (spur_en && lib_rd && $urandom_range(0, 3) == 0) begin
        dist_finished = 1'b1;
        dist2 = '0;
      end
      if (dist_ready && int'(lib_addr) != skip_idx) begin
        cnt = W;
        fire_a = int'(lib_addr);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT fires the calculator or completes.
  int            seen_gen = 0;
  int            exp_a = 0, exp_e = 0, rd_cnt = 0;
  bit            hold = 1'b0, busy_next = 1'b0;
  logic [MW-1:0] cur_a, cur_b;
  always @(negedge clk) begin
    fire_t f;
    res_t  r;
    if (reset) begin
      fire_q.delete();
      res_q.delete();
      hold = 1'b0;
      busy_next = 1'b0;
    end else begin
      if (gen != seen_gen) begin
        seen_gen = gen;
        exp_a = 0; exp_e = 0; rd_cnt = 0; hold = 1'b0;
      end
      if (busy_next) begin
        chk("busy_after_done", busy, 0);
        busy_next = 1'b0;
      end
      if (lib_rd || done) hold = 1'b0;
      if (hold) begin
        chk("hold_mtx_a", pack(mtx_a), cur_a);
        chk("hold_mtx_b", pack(mtx_b), cur_b);
      end
      if (lib_rd) begin
        if (quiet) chk("lib_rd_idle", lib_rd, 0);
        else begin
          chk("lib_addr", lib_addr, exp_a);
          chk("lib_entry", lib_entry, exp_e);
          rd_cnt++;
          if (exp_e == 7) begin exp_e = 0; exp_a++; end
          else exp_e++;
        end
      end
      if (dist_ready) begin
        if (fire_q.size() == 0) chk("ready_unexpected", dist_ready, 0);
        else begin
          f = fire_q.pop_front();
          chk("ready_cycle", cyc - start_cyc, f.off);
          chk("ready_addr", lib_addr, f.addr);
          chk("mtx_a", pack(mtx_a), f.a);
          chk("mtx_b", pack(mtx_b), f.b);
          if (f.addr == 0) begin
            chk("best_init_dist", best_dist2, {DW{1'b1}});
            chk("best_init_idx", best_idx, 0);
          end
          cur_a = f.a;
          cur_b = f.b;
          hold = 1'b1;
        end
      end
      if (done) begin
        if (res_q.size() == 0) chk("done_unexpected", done, 0);
        else begin
          r = res_q.pop_front();
          chk("done_latency", cyc - start_cyc, r.lat);
          chk("best_idx", best_idx, r.bidx);
          chk("best_dist2", best_dist2, r.bd);
          chk("timeout_err", timeout_err, r.tmo);
          chk("busy_at_done", busy, 1);
          chk("lib_rd_count", rd_cnt, 8*NC);
          busy_next = 1'b1;
        end
      end
    end
  end

  // Reference model: fixed per-candidate cost, strict-less minimum with lowest index on ties.
  task automatic prep(input int mode, input int w, input int skip, input bit spur);
    fire_t         f;
    res_t          r;
    logic [DW-1:0] best;
    int            bidx, t;
    W = w; skip_idx = skip; spur_en = spur;
    for (int k = 0; k < 16; k++)
      for (int e = 0; e < 8; e++)
        mem[k][e] = (mode == 0 && k == 0) ? NB'(e + 1) : NB'($urandom);
    tgt_flat = rand_mtx();
    for (int k = 0; k < NC; k++) begin
      case (mode)
        0:       dtab[k] = (k == 0) ? DW'(40) : (k == 3) ? DW'(99) : DW'(12);
        1:       dtab[k] = DW'($urandom_range(0, 7));
        2:       dtab[k] = DW'({$urandom, $urandom});
        default: dtab[k] = '1;
      endcase
    end
    best = '1; bidx = 0; t = 0;
    for (int k = 0; k < NC; k++) begin
      f.off = t + 10;
      f.addr = k;
      for (int e = 0; e < 8; e++) f.a[e*NB +: NB] = mem[k][e];
      f.b = tgt_flat;
      fire_q.push_back(f);
      if (k != skip && dtab[k] < best) begin best = dtab[k]; bidx = k; end
      t += 11 + ((k == skip) ? 15 : w);
    end
    r.lat = t + 1; r.bidx = bidx; r.bd = best; r.tmo = (skip >= 0);
    res_q.push_back(r);
    last_lat = r.lat; last_bidx = bidx; last_best = best;
  endtask

  task automatic issue(input bit collide);
    @(negedge clk);
    set_target(tgt_flat);
    start = 1'b1; gen++; start_cyc = cyc; quiet = 1'b0;
    @(negedge clk);
    start = 1'b0;
    set_target(rand_mtx());
    if (collide) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      set_target(rand_mtx());
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic finish_search(input bit start_on_done);
    bit got;
    got = 1'b0;
    for (int i = 0; i < last_lat + 60 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      chk("done_timeout", done, 1);
      fire_q.delete();
      res_q.delete();
    end
    quiet = 1'b1;
    if (start_on_done) begin
      start = 1'b1;
      set_target(rand_mtx());
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
    end
    chk("hold_best_idx", best_idx, last_bidx);
    chk("hold_best_dist2", best_dist2, last_best);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ready"}, dist_ready, 0);
    chk({tag, "_lib_rd"}, lib_rd, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
    chk({tag, "_addr"}, lib_addr, 0);
    chk({tag, "_entry"}, lib_entry, 0);
    chk({tag, "_bidx"}, best_idx, 0);
    chk({tag, "_bdist"}, best_dist2, {DW{1'b1}});
    chk({tag, "_mtx_a"}, pack(mtx_a), 0);
    chk({tag, "_mtx_b"}, pack(mtx_b), 0);
  endtask

  task automatic reset_mid_search();
    bit found;
    prep(2, 2, -1, 1'b0);
    issue(1'b0);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (lib_rd && lib_addr == 2) found = 1'b1;
    end
    chk("reach_cand2", found, 1);
    #2 reset = 1'b1;
    quiet = 1'b1;
    @(negedge clk);
    chk_reset("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
    end
    chk_reset("post_rst");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_target('0);
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;
    @(negedge clk);
    chk_reset("idle");

    prep(0, 2, -1, 1'b0); issue(1'b0); finish_search(1'b0);
    prep(1, 1, -1, 1'b1); issue(1'b1); finish_search(1'b1);
    for (int i = 0; i < 4; i++) begin
      prep(1 + (i % 2), $urandom_range(1, 5), -1, (i % 2) == 0);
      issue(1'b0);
      finish_search(1'b0);
    end
    prep(3, 3, -1, 1'b0); issue(1'b0); finish_search(1'b0);
    reset_mid_search();
`ifdef DIST_TIMEOUT_EN
    prep(1, 2, 1, 1'b0); issue(1'b0); finish_search(1'b0);
`endif
    prep(2, 1, -1, 1'b0); issue(1'b0); finish_search(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete by cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
